// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx_if
//  Purpose  : Command handshake between a requester and the PS/2 host
//             transmitter.
//  Signals  : TX_DATA  [7:0] byte to send, sampled with TX_START
//             TX_START       1-cycle request, honoured only while BUSY=0
//             BUSY           frame in flight (receive side should ignore lines)
//             DONE           1-cycle pulse, frame sent and ACK received
//             ERROR          1-cycle pulse, NACK or device timeout
//  Modports : master - command source, slave - ps2_host_tx
//  Revision : 1.0 - initial release
// ============================================================================
interface ps2_host_tx_if;
    logic [7:0] TX_DATA;
    logic       TX_START;
    logic       BUSY;
    logic       DONE;
    logic       ERROR;

    modport master (
        output TX_DATA,
        output TX_START,
        input  BUSY,
        input  DONE,
        input  ERROR
    );

    modport slave (
        input  TX_DATA,
        input  TX_START,
        output BUSY,
        output DONE,
        output ERROR
    );
endinterface
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Purpose  : PS/2 host-to-device transmitter. Inhibits the bus, issues the
//             request-to-send start bit, then shifts one byte (LSB first),
//             odd parity and stop bit out on device clock falling edges and
//             checks the device ACK bit.
//  Ports    : CLK, nRESET     system clock, asynchronous active-low reset
//             host (slave)    TX_DATA/TX_START/BUSY/DONE/ERROR handshake
//             PS2_CLK_IN      raw PS/2 clock line (asynchronous)
//             PS2_DATA_IN     raw PS/2 data line (asynchronous)
//             PS2_CLK_OE      1 = pull PS/2 clock low, 0 = release
//             PS2_DATA_OE     1 = pull PS/2 data low, 0 = release
//  Params   : INHIBIT_CYCLES  clock-low inhibit length (1..65536)
//             TIMEOUT_CYCLES  max cycles between device clock falls (1..65536)
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1600,
    parameter int TIMEOUT_CYCLES = 32000
) (
    input  wire logic    CLK,
    input  wire logic    nRESET,
    ps2_host_tx_if.slave host,
    input  wire logic    PS2_CLK_IN,
    input  wire logic    PS2_DATA_IN,
    output logic         PS2_CLK_OE,
    output logic         PS2_DATA_OE
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_REQ       = 3'd2;
    localparam logic [2:0] ST_SEND      = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    localparam logic [15:0] INHIBIT_LAST = 16'(INHIBIT_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic        clk_meta, clk_sync, clk_prev;
    logic        data_meta, data_sync;
    logic [9:0]  frame;       // {stop, parity, D7..D0}
    logic [15:0] timer;
    logic [3:0]  bit_cnt;     // device clock falls seen since the request
    logic        done_pulse, error_pulse;
    logic        clk_oe_nxt, data_oe_nxt, done_nxt, error_nxt;
    logic        fall, lines_idle, inhibit_last, timeout_hit;

    // Synchronisers reset to 1 (idle bus) so reset release never looks
    // like a falling edge.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= PS2_CLK_IN;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= PS2_DATA_IN;
            data_sync <= data_meta;
        end
    end

    assign fall         = clk_prev & ~clk_sync;
    assign lines_idle   = clk_sync & data_sync;
    assign inhibit_last = (timer == INHIBIT_LAST);
    // A falling edge in the same cycle wins over the timeout.
    assign timeout_hit  = (timer == TIMEOUT_LAST) & ~fall;

    // State register
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) state <= ST_IDLE;
        else         state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (host.TX_START) next_state = ST_INHIBIT;
            ST_INHIBIT:   if (inhibit_last)  next_state = ST_REQ;
            ST_REQ: begin
                if (fall)             next_state = ST_SEND;
                else if (timeout_hit) next_state = ST_IDLE;
            end
            ST_SEND: begin
                if (fall) begin
                    if (bit_cnt == 4'd9) next_state = ST_ACK;
                end else if (timeout_hit) begin
                    next_state = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (fall)             next_state = data_sync ? ST_IDLE : ST_WAIT_IDLE;
                else if (timeout_hit) next_state = ST_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (lines_idle)       next_state = ST_IDLE;
                else if (timeout_hit) next_state = ST_IDLE;
            end
            default:                  next_state = ST_IDLE;
        endcase
    end

    // Output logic: next values for the registered line drivers and pulses,
    // so nothing driving the open-collector pads can glitch.
    always_comb begin
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = PS2_DATA_OE;
        done_nxt    = 1'b0;
        error_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                data_oe_nxt = 1'b0;
                clk_oe_nxt  = host.TX_START;
            end
            ST_INHIBIT: begin
                clk_oe_nxt = ~inhibit_last;
                if (inhibit_last) data_oe_nxt = 1'b1;   // start bit
            end
            ST_REQ, ST_SEND: begin
                // Device latches on its rising edge; we change data while
                // the clock is low. Driving low means a 0 bit.
                if (fall) begin
                    data_oe_nxt = ~frame[bit_cnt];
                end else if (timeout_hit) begin
                    data_oe_nxt = 1'b0;
                    error_nxt   = 1'b1;
                end
            end
            ST_ACK: begin
                data_oe_nxt = 1'b0;
                if (fall)             error_nxt = data_sync;   // high = NACK
                else if (timeout_hit) error_nxt = 1'b1;
            end
            ST_WAIT_IDLE: begin
                data_oe_nxt = 1'b0;
                if (lines_idle)       done_nxt  = 1'b1;
                else if (timeout_hit) error_nxt = 1'b1;
            end
            default: data_oe_nxt = 1'b0;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            frame       <= '0;
            timer       <= '0;
            bit_cnt     <= '0;
            PS2_CLK_OE  <= 1'b0;
            PS2_DATA_OE <= 1'b0;
            done_pulse  <= 1'b0;
            error_pulse <= 1'b0;
        end else begin
            PS2_CLK_OE  <= clk_oe_nxt;
            PS2_DATA_OE <= data_oe_nxt;
            done_pulse  <= done_nxt;
            error_pulse <= error_nxt;
            case (state)
                ST_IDLE: begin
                    if (host.TX_START) begin
                        frame   <= {1'b1, ~^host.TX_DATA, host.TX_DATA};
                        timer   <= '0;
                        bit_cnt <= '0;
                    end
                end
                ST_INHIBIT: timer <= inhibit_last ? 16'd0 : timer + 16'd1;
                default: begin
                    timer <= fall ? 16'd0 : timer + 16'd1;
                    if (fall) bit_cnt <= bit_cnt + 4'd1;
                end
            endcase
        end
    end

    // BUSY falls in the same cycle the registered DONE/ERROR pulse appears.
    assign host.BUSY  = (state != ST_IDLE);
    assign host.DONE  = done_pulse;
    assign host.ERROR = error_pulse;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_host_tx
//  Purpose  : Self-checking bench for ps2_host_tx with a behavioural PS/2
//             device on open-collector wires.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TO  = 300;

    logic CLK    = 1'b0;
    logic nRESET = 1'b0;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic PS2_CLK_OE, PS2_DATA_OE;
    logic clk_line, data_line;

    always #5 CLK = ~CLK;

    assign clk_line  = ~(PS2_CLK_OE  | dev_clk_low);
    assign data_line = ~(PS2_DATA_OE | dev_data_low);

    ps2_host_tx_if bus ();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .host       (bus),
        .PS2_CLK_IN (clk_line),
        .PS2_DATA_IN(data_line),
        .PS2_CLK_OE (PS2_CLK_OE),
        .PS2_DATA_OE(PS2_DATA_OE)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    int cyc = 0;
    int oe_run = 0, last_run = 0, frames = 0;
    int done_cnt = 0, err_cnt = 0, err_cyc = 0, fall_cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (PS2_CLK_OE) oe_run++;
        else if (oe_run != 0) begin
            last_run = oe_run;
            oe_run   = 0;
            frames++;
        end
        if (bus.DONE || bus.ERROR) begin
            check("pulse_exclusive", 32'(bus.DONE & bus.ERROR), 0);
            check("busy_at_pulse", 32'(bus.BUSY), 0);
        end
        if (bus.DONE)  done_cnt++;
        if (bus.ERROR) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    // ---------------- device model ----------------
    // Waits for the request-to-send, then clocks n_edges falling edges
    // (6 cycles low, 6 high). The bit the host presents after edge e is
    // sampled just before the next fall. bits[0] is the start bit.
    task automatic device_frame(input bit ack_it, input int n_edges, output logic [10:0] bits);
        int guard;
        bits  = '0;
        guard = 0;
        @(negedge CLK);
        while (!(bus.BUSY && !PS2_CLK_OE && PS2_DATA_OE) && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        check("request_seen", 32'(guard < 200), 1);
        if (guard >= 200) return;
        bits[0] = data_line;
        for (int e = 1; e <= n_edges; e++) begin
            if (e == 11 && ack_it) dev_data_low = 1'b1;
            repeat (2) @(negedge CLK);
            dev_clk_low = 1'b1;
            fall_cyc    = cyc;
            repeat (6) @(negedge CLK);
            dev_clk_low = 1'b0;
            repeat (6) @(negedge CLK);
            if (e <= 10) bits[e] = data_line;
        end
        if (dev_data_low) begin
            repeat (3) @(negedge CLK);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        @(negedge CLK);
        bus.TX_DATA  = d;
        bus.TX_START = 1'b1;
        @(negedge CLK);
        bus.TX_START = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (bus.BUSY && g < TO + 100) begin
            @(negedge CLK);
            g++;
        end
        check("busy_released", 32'(bus.BUSY), 0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0] data;
        logic       par;       // hand-computed odd parity bit
        bit         ack;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t        vecs[6];
    logic [10:0] fbits;
    int          d0, e0, f0;

    initial begin
        vecs[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1, 0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1, 0};
        vecs[4] = '{8'h80, 1'b0, 1'b0, 0, 1};   // device NACKs
        vecs[5] = '{8'h55, 1'b1, 1'b1, 1, 0};

        bus.TX_DATA  = 8'h00;
        bus.TX_START = 1'b0;
        repeat (4) @(negedge CLK);
        check("rst_busy",    32'(bus.BUSY), 0);
        check("rst_done",    32'(bus.DONE), 0);
        check("rst_error",   32'(bus.ERROR), 0);
        check("rst_clk_oe",  32'(PS2_CLK_OE), 0);
        check("rst_data_oe", 32'(PS2_DATA_OE), 0);
        nRESET = 1'b1;
        repeat (3) @(negedge CLK);

        for (int i = 0; i < 6; i++) begin
            d0 = done_cnt; e0 = err_cnt; f0 = frames;
            start_tx(vecs[i].data);
            check($sformatf("busy_after_start[%0d]", i), 32'(bus.BUSY), 1);
            device_frame(vecs[i].ack, 11, fbits);
            wait_idle();
            repeat (2) @(negedge CLK);
            check($sformatf("wire_frame[%0d]", i), 32'(fbits),
                  32'({1'b1, vecs[i].par, vecs[i].data, 1'b0}));
            check($sformatf("inhibit_len[%0d]", i), 32'(last_run), INH);
            check($sformatf("frames[%0d]", i), 32'(frames - f0), 1);
            check($sformatf("done_pulses[%0d]", i), 32'(done_cnt - d0), 32'(vecs[i].exp_done));
            check($sformatf("error_pulses[%0d]", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
            check($sformatf("lines_released[%0d]", i), 32'({PS2_CLK_OE, PS2_DATA_OE}), 0);
        end

        // TX_START while busy is ignored
        d0 = done_cnt; f0 = frames;
        start_tx(8'hED);
        fork
            device_frame(1'b1, 11, fbits);
            begin
                repeat (60) @(negedge CLK);
                bus.TX_DATA  = 8'h55;
                bus.TX_START = 1'b1;
                @(negedge CLK);
                bus.TX_START = 1'b0;
            end
        join
        wait_idle();
        repeat (30) @(negedge CLK);
        check("busy_ign_frame",  32'(fbits), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
        check("busy_ign_frames", 32'(frames - f0), 1);
        check("busy_ign_done",   32'(done_cnt - d0), 1);
        check("busy_ign_idle",   32'(bus.BUSY), 0);

        // Device stops clocking after edge 4 -> timeout
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'h12);
        device_frame(1'b0, 4, fbits);
        check("to_data_held", 32'(PS2_DATA_OE), 1);     // D3 of 0x12 is 0
        wait_idle();
        repeat (2) @(negedge CLK);
        check("to_bits",     32'(fbits[4:0]), 32'(5'b00100));
        check("to_error",    32'(err_cnt - e0), 1);
        check("to_no_done",  32'(done_cnt - d0), 0);
        check("to_latency",  32'(err_cyc - fall_cyc), 32'(TO + 3));
        check("to_released", 32'({PS2_CLK_OE, PS2_DATA_OE}), 0);

        // Asynchronous reset in SEND
        start_tx(8'h30);
        device_frame(1'b1, 3, fbits);
        check("rs_data_oe_pre", 32'(PS2_DATA_OE), 1);   // D2 of 0x30 is 0
        check("rs_busy_pre",    32'(bus.BUSY), 1);
        @(posedge CLK);
        #3 nRESET = 1'b0;
        #1;
        check("rs_clk_oe",  32'(PS2_CLK_OE), 0);
        check("rs_data_oe", 32'(PS2_DATA_OE), 0);
        check("rs_busy",    32'(bus.BUSY), 0);
        repeat (3) @(negedge CLK);
        nRESET = 1'b1;
        repeat (3) @(negedge CLK);
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hA7);
        device_frame(1'b1, 11, fbits);
        wait_idle();
        repeat (2) @(negedge CLK);
        check("rs_new_frame", 32'(fbits), 32'({1'b1, 1'b0, 8'hA7, 1'b0}));
        check("rs_new_done",  32'(done_cnt - d0), 1);
        check("rs_new_err",   32'(err_cnt - e0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
